// File: rtl/bin2bcd_display_feeder.sv
// -----------------------------------------------------------------------------
// bin2bcd_display_feeder
//
// Sequential double-dabble converter: turns a 32-bit unsigned value into eight
// packed BCD digits for the 8-digit 7-segment driver. It also produces a
// leading-zero blank mask and an overflow flag for values above 99_999_999.
// The outputs change only when a conversion finishes, so the display never
// shows intermediate values.
//
// Parameters:
//   SATURATE  1: on overflow bcd_out = 32'h9999_9999; 0: low 8 decimal digits
//   BLANK_EN  1: blank computed from leading zeros;  0: blank held at 8'h00
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   conversion request, sampled only when idle
//   bin_in   in   32  binary value, captured on the accepted start edge
//   busy     out  1   conversion in progress
//   done     out  1   one-cycle pulse when new results are valid
//   bcd_out  out  32  8 packed BCD digits, [3:0] = units
//   blank    out  8   bit i = digit i is a leading zero (bit 0 never set)
//   ovf      out  1   last converted value was > 99_999_999
// -----------------------------------------------------------------------------
module bin2bcd_display_feeder #(
    parameter bit SATURATE = 1'b1,
    parameter bit BLANK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd_out,
    output logic [7:0]  blank,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [7:0]  BLANK_RESET = BLANK_EN ? 8'hFE : 8'h00;
    localparam logic [5:0]  LAST_SHIFT  = 6'd31;
    localparam logic [31:0] ALL_NINES   = 32'h9999_9999;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] shreg;
    logic [39:0] bcd_acc;
    logic [5:0]  count;

    logic [39:0] acc_adj;
    logic        fin_ovf;
    logic [31:0] fin_bcd;
    logic [7:0]  fin_blank;
    logic        lead_zero;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // count holds the number of shifts already done; this edge
                // performs the 32nd one.
                if (count == LAST_SHIFT) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // ---------------------------------------------------------------------
    // Double-dabble correction: every nibble >= 5 gets +3 (4-bit, no carry
    // between nibbles) before the shift.
    // ---------------------------------------------------------------------
    always_comb begin
        acc_adj = bcd_acc;
        for (int unsigned i = 0; i < 10; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Final result formatting from the completed accumulator
    // ---------------------------------------------------------------------
    always_comb begin
        fin_ovf = |bcd_acc[39:32];
        fin_bcd = bcd_acc[31:0];
        if (fin_ovf && SATURATE) begin
            fin_bcd = ALL_NINES;
        end
    end

    // Scan from the most significant digit down; a digit is blanked while
    // every digit at or above it is zero. Units digit is always shown.
    always_comb begin
        fin_blank = '0;
        lead_zero = 1'b1;
        if (BLANK_EN) begin
            for (int unsigned i = 7; i >= 1; i--) begin
                lead_zero    = lead_zero & (fin_bcd[4*i +: 4] == 4'd0);
                fin_blank[i] = lead_zero;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Datapath and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bcd_acc <= '0;
            count   <= '0;
            done    <= 1'b0;
            bcd_out <= '0;
            blank   <= BLANK_RESET;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        bcd_acc <= '0;
                        count   <= '0;
                    end
                end
                SHIFT: begin
                    // {bcd_acc, shreg} <<= 1 using the corrected accumulator
                    {bcd_acc, shreg} <= {acc_adj[38:0], shreg, 1'b0};
                    count            <= count + 6'd1;
                end
                FINISH: begin
                    bcd_out <= fin_bcd;
                    blank   <= fin_blank;
                    ovf     <= fin_ovf;
                    done    <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_display_feeder.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_display_feeder
//
// Scoreboard bench for bin2bcd_display_feeder. Two instances share clock and
// reset: u_sat (SATURATE=1) and u_wrap (SATURATE=0), both with BLANK_EN=1.
// Stimulus pushes hand-computed expected results into per-instance queues;
// a monitor pops and compares whenever an instance pulses done.
// -----------------------------------------------------------------------------
module tb_bin2bcd_display_feeder;

    typedef struct packed {
        logic [31:0] bcd;
        logic [7:0]  blank;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  start;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  ovf;
    logic [31:0] bin_in  [2];
    logic [31:0] bcd_out [2];
    logic [7:0]  blank   [2];

    exp_t q0[$];
    exp_t q1[$];

    int   checks = 0;
    int   fails  = 0;
    logic [1:0] prev_done = 2'b00;

    always #5 clk = ~clk;

    bin2bcd_display_feeder #(.SATURATE(1'b1), .BLANK_EN(1'b1)) u_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start[0]),
        .bin_in  (bin_in[0]),
        .busy    (busy[0]),
        .done    (done[0]),
        .bcd_out (bcd_out[0]),
        .blank   (blank[0]),
        .ovf     (ovf[0])
    );

    bin2bcd_display_feeder #(.SATURATE(1'b0), .BLANK_EN(1'b1)) u_wrap (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start[1]),
        .bin_in  (bin_in[1]),
        .busy    (busy[1]),
        .done    (done[1]),
        .bcd_out (bcd_out[1]),
        .blank   (blank[1]),
        .ovf     (ovf[1])
    );

    function automatic exp_t mk(input logic [31:0] b, input logic [7:0] bl, input logic o);
        exp_t e;
        e.bcd   = b;
        e.blank = bl;
        e.ovf   = o;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare results whenever an instance pulses done
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (done[d] === 1'b1) begin
                chk($sformatf("done_single_cycle[%0d]", d), {31'b0, prev_done[d]}, 32'd0);
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done[%0d]: got done=1, expected no done", d);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("bcd_out[%0d]", d), bcd_out[d], e.bcd);
                    chk($sformatf("blank[%0d]", d), {24'b0, blank[d]}, {24'b0, e.blank});
                    chk($sformatf("ovf[%0d]", d), {31'b0, ovf[d]}, {31'b0, e.ovf});
                end
            end
        end
        prev_done = done;
    end

    // One conversion on instance d; optional glitch start/bin_in change mid-run
    task automatic run_conv(input int d, input logic [31:0] v, input exp_t e, input bit glitch);
        int   n;
        int   busy_cnt;
        logic seen;
        @(negedge clk);
        bin_in[d] = v;
        start[d]  = 1'b1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        busy_cnt = busy[d] ? 1 : 0;
        n        = 0;
        seen     = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (glitch && n == 10) begin
                start[d]  = 1'b1;
                bin_in[d] = 32'd7;
            end
            if (glitch && n == 11) begin
                start[d]  = 1'b0;
                bin_in[d] = 32'hDEAD_BEEF;
            end
            if (done[d]) seen = 1'b1;
            else if (busy[d]) busy_cnt++;
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL timeout[%0d]: got no done in 40 cycles, expected done at 33 for %h", d, v);
            if (d == 0 && q0.size() > 0) void'(q0.pop_back());
            if (d == 1 && q1.size() > 0) void'(q1.pop_back());
        end else begin
            chk($sformatf("latency[%0d]", d), n, 32'd33);
            chk($sformatf("busy_cycles[%0d]", d), busy_cnt, 32'd33);
            chk($sformatf("busy_low_in_done[%0d]", d), {31'b0, busy[d]}, 32'd0);
        end
    endtask

    initial begin
        logic seen;
        start     = 2'b00;
        bin_in[0] = '0;
        bin_in[1] = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  {30'b0, busy}, 32'd0);
        chk("reset_done",  {30'b0, done}, 32'd0);
        chk("reset_ovf",   {30'b0, ovf},  32'd0);
        chk("reset_bcd0",  bcd_out[0], 32'h0000_0000);
        chk("reset_bcd1",  bcd_out[1], 32'h0000_0000);
        chk("reset_blank0", {24'b0, blank[0]}, 32'h0000_00FE);
        chk("reset_blank1", {24'b0, blank[1]}, 32'h0000_00FE);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturating instance
        run_conv(0, 32'd0,           mk(32'h0000_0000, 8'hFE, 1'b0), 1'b0);
        run_conv(0, 32'd12_345_678,  mk(32'h1234_5678, 8'h00, 1'b0), 1'b0);
        run_conv(0, 32'd905,         mk(32'h0000_0905, 8'hF8, 1'b0), 1'b0);
        run_conv(0, 32'd99_999_999,  mk(32'h9999_9999, 8'h00, 1'b0), 1'b0);
        run_conv(0, 32'd100_000_000, mk(32'h9999_9999, 8'h00, 1'b1), 1'b0);

        // Wrapping instance
        run_conv(1, 32'hFFFF_FFFF,   mk(32'h9496_7295, 8'h00, 1'b1), 1'b0);
        run_conv(1, 32'd100_000_000, mk(32'h0000_0000, 8'hFE, 1'b1), 1'b0);
        run_conv(1, 32'd7,           mk(32'h0000_0007, 8'hFE, 1'b0), 1'b0);

        // Start and bin_in changes during a conversion are ignored
        run_conv(0, 32'd42,          mk(32'h0000_0042, 8'hFC, 1'b0), 1'b1);
        // Start in the cycle after done
        @(posedge clk);
        run_conv(0, 32'd1234,        mk(32'h0000_1234, 8'hF0, 1'b0), 1'b0);

        // Reset mid-conversion: abort with no done pulse
        @(negedge clk);
        bin_in[0] = 32'd5678;
        start[0]  = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("hold_bcd_while_busy", bcd_out[0], 32'h0000_1234);
        chk("busy_mid_conv", {31'b0, busy[0]}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  {31'b0, busy[0]}, 32'd0);
        chk("abort_done",  {31'b0, done[0]}, 32'd0);
        chk("abort_bcd",   bcd_out[0], 32'h0000_0000);
        chk("abort_blank", {24'b0, blank[0]}, 32'h0000_00FE);
        chk("abort_ovf",   {31'b0, ovf[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done[0]) seen = 1'b1;
        end
        chk("no_done_after_abort", {31'b0, seen}, 32'd0);

        run_conv(0, 32'd5678,        mk(32'h0000_5678, 8'hF0, 1'b0), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue0_drained", q0.size(), 32'd0);
        chk("queue1_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running at 100000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
